// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// ALUOp / PCSrc / RegDst codes and the static decode bundle.
package mcu_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b100111;
  localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OP_W-1:0] OP_J     = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alu_src_a;
    logic               alu_src_b;
    logic               ext_sel;
    logic [1:0]         reg_dst;
    logic               db_data_src;
    logic               alu_wr;       // opcode writes an ALU result in WB_AL
  } dec_t;

endpackage

// File: rtl/mcu_decode.sv
// Combinational opcode -> static datapath control fields; no state, zero latency.
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output dec_t            dec_o
);

  always_comb begin
    dec_o.aluop       = ALU_ADD;
    dec_o.alu_src_a   = 1'b0;
    dec_o.alu_src_b   = 1'b0;
    dec_o.ext_sel     = 1'b1;
    dec_o.reg_dst     = RD_RT;
    dec_o.db_data_src = 1'b0;
    dec_o.alu_wr      = 1'b0;
    case (opcode_i)
      OP_ADD:   begin dec_o.reg_dst = RD_RD; dec_o.alu_wr = 1'b1; end
      OP_SUB:   begin dec_o.aluop = ALU_SUB; dec_o.reg_dst = RD_RD; dec_o.alu_wr = 1'b1; end
      OP_AND:   begin dec_o.aluop = ALU_AND; dec_o.reg_dst = RD_RD; dec_o.alu_wr = 1'b1; end
      OP_SLT:   begin dec_o.aluop = ALU_SLT; dec_o.reg_dst = RD_RD; dec_o.alu_wr = 1'b1; end
      OP_SLL: begin
        dec_o.aluop     = ALU_SLL;
        dec_o.alu_src_a = 1'b1;
        dec_o.reg_dst   = RD_RD;
        dec_o.alu_wr    = 1'b1;
      end
      OP_ADDIU: begin dec_o.alu_src_b = 1'b1; dec_o.alu_wr = 1'b1; end
      OP_ANDI: begin
        dec_o.aluop     = ALU_AND;
        dec_o.alu_src_b = 1'b1;
        dec_o.ext_sel   = 1'b0;
        dec_o.alu_wr    = 1'b1;
      end
      OP_ORI: begin
        dec_o.aluop     = ALU_OR;
        dec_o.alu_src_b = 1'b1;
        dec_o.ext_sel   = 1'b0;
        dec_o.alu_wr    = 1'b1;
      end
      OP_SLTI:  begin dec_o.aluop = ALU_SLT; dec_o.alu_src_b = 1'b1; dec_o.alu_wr = 1'b1; end
      OP_SW:    dec_o.alu_src_b = 1'b1;
      OP_LW:    begin dec_o.alu_src_b = 1'b1; dec_o.db_data_src = 1'b1; end
      // bltz relies on rt = $0, so rs - 0 exposes the sign of rs
      OP_BEQ, OP_BNE, OP_BLTZ: dec_o.aluop = ALU_SUB;
      OP_JAL:   dec_o.reg_dst = RD_RA;
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: state register plus per-state strobe gating over
// the static decode; outputs combinational from state/opcode/flags, reset forces strobes low.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPW    = OP_W,
  parameter int ALUOPW = ALUOP_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              sign,
  output logic              PCWre,
  output logic              IRWre,
  output logic              InsMemRW,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic              ExtSel,
  output logic              RegWre,
  output logic [1:0]        RegDst,
  output logic              WrRegDSrc,
  output logic              DBDataSrc,
  output logic              mRD,
  output logic              mWR,
  output logic [1:0]        PCSrc,
  output logic [ALUOPW-1:0] ALUOp,
  output logic [2:0]        state_out
);

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  dec_t   dec;
  logic   is_lw, is_sw, is_jal, is_jr, is_jump, is_branch, br_taken;

  mcu_decode u_decode (
    .opcode_i (opcode),
    .dec_o    (dec)
  );

  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jr     = (opcode == OP_JR);
  assign is_jump   = is_jal | is_jr | (opcode == OP_J);
  assign is_branch = (opcode == OP_BEQ) | (opcode == OP_BNE) | (opcode == OP_BLTZ);
  assign br_taken  = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero) |
                     ((opcode == OP_BLTZ) & sign);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // halt parks the FSM in IF with the PC frozen; only reset clears it
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      S_IF: state_d = halted_q ? S_IF : S_ID;
      S_ID: begin
        if (is_jump) begin
          state_d = S_IF;
        end else if (opcode == OP_HALT) begin
          state_d  = S_IF;
          halted_d = 1'b1;
        end else if (is_branch) begin
          state_d = S_EXE_BR;
        end else if (is_lw | is_sw) begin
          state_d = S_EXE_LS;
        end else begin
          state_d = S_EXE_AL;
        end
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = PC_SEQ;
    RegDst    = dec.reg_dst;
    ALUOp     = dec.aluop;
    ALUSrcA   = dec.alu_src_a;
    ALUSrcB   = dec.alu_src_b;
    ExtSel    = dec.ext_sel;
    DBDataSrc = dec.db_data_src;
    WrRegDSrc = ~is_jal;
    case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      S_ID: begin
        PCWre  = is_jump;
        RegWre = is_jal;
        if (is_jr)        PCSrc = PC_JR;
        else if (is_jump) PCSrc = PC_JMP;
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = br_taken ? PC_BR : PC_SEQ;
      end
      S_MEM: begin
        mRD   = is_lw;
        mWR   = is_sw;
        PCWre = is_sw;
      end
      S_WB_AL: begin
        PCWre  = 1'b1;
        RegWre = dec.alu_wr;
      end
      S_WB_LD: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      default: ;
    endcase
    if (!RST) begin
      PCWre    = 1'b0;
      IRWre    = 1'b0;
      InsMemRW = 1'b0;
      RegWre   = 1'b0;
      mRD      = 1'b0;
      mWR      = 1'b0;
      RegDst   = RD_RT;
      PCSrc    = PC_SEQ;
    end
  end

  assign state_out = state_q;

endmodule
